// File: rtl/cycle_sequencer.sv
// T-state / M-cycle timing generator feeding the per-instruction microcode blocks.
// Optional single-step mode (adds i_Step_Req) is enabled by defining CYCLE_SEQ_SINGLE_STEP_EN.
module cycle_sequencer #(
  parameter int unsigned STEPS   = 4,
  parameter int unsigned MCYCLES = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Enable,
  input  logic               i_Wait,
  input  logic               i_IR_Fetch,
  input  logic               i_Halt,
  input  logic               i_Wake,
`ifdef CYCLE_SEQ_SINGLE_STEP_EN
  input  logic               i_Step_Req,
`endif
  output logic [STEPS-1:0]   o_Cycle_Step,
  output logic [MCYCLES-1:0] o_Cycle_Count,
  output logic               o_Instr_Start,
  output logic               o_Halted,
  output logic               o_Overflow
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [STEPS-1:0]   STEP_FIRST  = STEPS'(1);
  localparam logic [MCYCLES-1:0] COUNT_FIRST = MCYCLES'(1);

  state_t               state_q, state_d;
  logic [STEPS-1:0]     step_q, step_d;
  logic [MCYCLES-1:0]   count_q, count_d;
  logic                 start_q, start_d;
  logic                 ovf_q, ovf_d;
  logic                 step_go;

`ifdef CYCLE_SEQ_SINGLE_STEP_EN
  assign step_go = i_Step_Req;
`else
  assign step_go = 1'b1;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_RUN;
      step_q  <= STEP_FIRST;
      count_q <= COUNT_FIRST;
      start_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      count_q <= count_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    count_d = count_q;
    start_d = start_q;
    ovf_d   = ovf_q;
    if (i_Enable) begin
      unique case (state_q)
        ST_RUN: begin
          if (step_go) begin
            start_d = 1'b0;
            if (step_q[2] && i_Wait) begin
              state_d = ST_STALL;
            end else if (step_q[STEPS-1]) begin
              step_d = STEP_FIRST;
              if (i_IR_Fetch) begin
                count_d = COUNT_FIRST;
                if (i_Halt) state_d = ST_HALT;
                else        start_d = 1'b1;
              end else if (count_q[MCYCLES-1]) begin
                // Ran off the end without an IR fetch: flag it and force a refetch.
                ovf_d   = 1'b1;
                count_d = COUNT_FIRST;
                start_d = 1'b1;
              end else begin
                count_d = count_q << 1;
              end
            end else begin
              step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};
            end
          end
        end
        ST_STALL: begin
          // The clock that sees i_Wait drop also completes the held T-state.
          if (!i_Wait) begin
            state_d = ST_RUN;
            step_d  = {step_q[STEPS-2:0], step_q[STEPS-1]};
          end
        end
        ST_HALT: begin
          step_d  = STEP_FIRST;
          count_d = COUNT_FIRST;
          if (i_Wake) begin
            state_d = ST_RUN;
            start_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          step_d  = STEP_FIRST;
          count_d = COUNT_FIRST;
          start_d = 1'b1;
        end
      endcase
    end
  end

  assign o_Cycle_Step  = step_q;
  assign o_Cycle_Count = count_q;
  assign o_Instr_Start = start_q && i_Enable && (state_q == ST_RUN);
  assign o_Halted      = (state_q == ST_HALT);
  assign o_Overflow    = ovf_q;

endmodule
